multich_frame_normalizer: RTL and testbench
===========================================

# multich_frame_normalizer

Parametrised multi-channel frame normalizer that follows the multi-channel FIR stage. It captures one frame of FRAME samples per channel into an internal buffer and tracks the per-channel peak magnitude. It then replays the frame with each channel left-shifted by the largest power of two that keeps its peak inside the signed range. Compared with the fixed 11-channel normalizer bank, it adds generic channel count and width, an internal frame buffer, a selectable bypass mode, reported per-channel shift values and a valid/ready output handshake.

## Interface
- CH, 11, number of channels
- DW, 32, signed sample width per channel
- FRAME, 1000, samples per channel per frame (≥2)
- SW, $clog2(DW), width of each shift field
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start_flag  in  1  one-cycle request to begin a frame; honoured only in IDLE
- mode  in  1  0 = peak normalize, 1 = bypass (shift forced 0); sampled on the accepted start_flag
- data_in  in  CH*DW  packed samples, channel 0 in MSBs
- data_in_valid  in  1  input sample strobe
- data_in_ready  out  1  high only in CAPTURE
- data_out  out  CH*DW  normalized samples, channel 0 in MSBs
- data_out_valid  out  1  output sample valid
- data_out_ready  in  1  downstream accept
- shift_out  out  CH*SW  per-channel applied shift, channel 0 in MSBs; valid from CALC until next start
- process_end_flag  out  1  one-cycle pulse after the last output handshake

## Operation
- States: IDLE → CAPTURE → CALC → PREFETCH → OUTPUT → IDLE.
- IDLE:
  - start_flag=1 latches mode, clears peaks and the write pointer, and enters CAPTURE.
  - data_in_valid is ignored.
- CAPTURE: on each data_in_valid (data_in_ready=1):
  - Write data_in to buffer[wptr] and increment wptr.
  - Per channel, compute m = |x| as a DW-bit unsigned value, so that |−2^(DW−1)| = 2^(DW−1). Update peak = max(peak, m).
  - After the FRAME-th write, go to CALC.
- CALC (1 cycle), per channel:
  - s is the largest value in [0, DW−2] with peak·2^s ≤ 2^(DW−1)−1.
  - s=0 if peak=0, if peak ≥ 2^(DW−2), or if mode=1.
  - Register s into shift_out. Reset the read pointer.
- PREFETCH (1 cycle): issue the buffer read of address 0.
- OUTPUT:
  - data_out = per-channel (x <<< s), registered. The shift never overflows by construction, so no saturation logic is needed.
  - data_out_valid stays high until the handshake (valid&ready). data_out and data_out_valid are stable while valid & !ready.
  - Each handshake advances to the next address, with no bubble when ready stays high.
  - After the FRAME-th handshake: data_out_valid=0, process_end_flag=1 for one cycle, return to IDLE.
- start_flag outside IDLE is ignored. data_in_valid outside CAPTURE is dropped.
- The buffer is FRAME×(CH*DW) and holds exactly one frame. Capture and output do not overlap.
- Reset (any state, including mid-CAPTURE or mid-OUTPUT) returns to IDLE and discards the frame.

## Timing
- Reset values: data_in_ready=0, data_out=0, data_out_valid=0, shift_out=0, process_end_flag=0, and all peaks and pointers 0.
- start_flag accepted at cycle T → data_in_ready=1 at T+1.
- Last input accepted at C → CALC at C+1 (data_in_ready=0), PREFETCH at C+2, first data_out_valid=1 at C+3. shift_out is valid from C+2.
- With data_out_ready held high, one sample per cycle: cycles C+3 … C+2+FRAME. process_end_flag pulses at C+3+FRAME.
- The earliest next start_flag is accepted in the cycle after process_end_flag.

## Test plan
Bench parameters: CH=2, DW=16, FRAME=4.
1. **Reset:** hold rst_n=0 for 3 cycles with random inputs → all outputs 0 and data_in_ready=0. A start_flag during reset has no effect.
2. **Normalize:** mode=0; ch0 = 1, −2, 3, 0; ch1 = 0, 0, 0, 0; ready=1 → shift_out ch0=13, ch1=0. ch0 outputs 8192, −16384, 24576, 0; ch1 outputs all 0. Valid for 4 consecutive cycles, then one process_end_flag pulse.
3. **Full-scale / negative extreme:** ch0 = 100, −32768, 5, 7 → s=0 and outputs unchanged. ch1 = 16383, −1, 2, 0 → s=1, outputs 32766, −2, 4, 0.
4. **Backpressure:** same stimulus as scenario 2, with data_out_ready=0 for 3 cycles during the second sample → data_out holds −16384 with valid high. All 4 samples are delivered exactly once; process_end_flag follows the 4th handshake.
5. **Bypass and gaps:** mode=1 with ch0 = 1, −2, 3, 0, and data_in_valid toggling on/off → shift_out=0 and outputs equal inputs. Samples presented while data_in_ready=0 do not enter the buffer.
6. **Reset mid-OUTPUT / start while busy:**
   - A start_flag pulsed in CAPTURE and in OUTPUT is ignored.
   - rst_n=0 for 1 cycle after the 2nd output → IDLE with all outputs 0.
   - A new frame then runs correctly from a fresh start_flag.

Source files
------------

// File: rtl/multich_frame_normalizer.sv
// Multi-channel frame normalizer. It buffers one frame per channel and tracks
// each channel's peak magnitude. It then replays the frame with every channel
// left-shifted by the largest amount that keeps its peak within signed range.
//
// Output handshake: data_out/data_out_valid are registers. A sample transfers on
// any rising edge where data_out_valid && data_out_ready. While valid is high and
// ready is low, both data_out and data_out_valid hold.
// Input side: a sample is taken on any rising edge where data_in_valid &&
// data_in_ready. data_in_ready is high only in CAPTURE.
module multich_frame_normalizer #(
  parameter int CH    = 11,
  parameter int DW    = 32,
  parameter int FRAME = 1000,
  parameter int SW    = $clog2(DW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_flag,
  input  logic             mode,
  input  logic [CH*DW-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [CH*DW-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic [CH*SW-1:0] shift_out,
  output logic             process_end_flag
);

  localparam int AW = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CAPTURE  = 3'd1;
  localparam logic [2:0] S_CALC     = 3'd2;
  localparam logic [2:0] S_PREFETCH = 3'd3;
  localparam logic [2:0] S_OUTPUT   = 3'd4;

  logic [2:0]             state;
  logic                   mode_q;
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [AW-1:0]          rptr_nxt;
  logic [CH-1:0][DW-1:0]  peak;
  logic [CH*DW-1:0]       mem [FRAME];

  // Unsigned magnitude; the most negative value maps to 2^(DW-1), which fits in DW bits.
  function automatic logic [DW-1:0] abs_mag(input logic [DW-1:0] x);
    return x[DW-1] ? (~x + DW'(1)) : x;
  endfunction

  // Largest shift keeping peak << s below 2^(DW-1): one less than the leading
  // zero count. Zero peaks and peaks already in the top two bits get no shift.
  function automatic logic [SW-1:0] calc_shift(input logic [DW-1:0] p);
    int msb;
    msb = -1;
    for (int b = 0; b < DW; b++) begin
      if (p[b]) msb = b;
    end
    if (msb < 0 || msb >= DW - 2) return '0;
    return SW'(DW - 2 - msb);
  endfunction

  // Apply each channel's shift to a packed sample word (channel 0 in MSBs).
  function automatic logic [CH*DW-1:0] apply_shift(input logic [CH*DW-1:0] x,
                                                    input logic [CH*SW-1:0] sh);
    logic [CH*DW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      r[(CH-1-c)*DW +: DW] = x[(CH-1-c)*DW +: DW] << sh[(CH-1-c)*SW +: SW];
    end
    return r;
  endfunction

  assign data_in_ready = (state == S_CAPTURE);
  assign rptr_nxt      = rptr + AW'(1);

  // Frame buffer write port; contents are don't-care until a frame is captured.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE && data_in_valid) mem[wptr] <= data_in;
  end

  // Control FSM, peak tracking, shift calculation and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      mode_q           <= 1'b0;
      wptr             <= '0;
      rptr             <= '0;
      peak             <= '0;
      shift_out        <= '0;
      data_out         <= '0;
      data_out_valid   <= 1'b0;
      process_end_flag <= 1'b0;
    end else begin
      process_end_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          // The cycle carrying the end pulse is not yet open for a new start.
          if (start_flag && !process_end_flag) begin
            mode_q <= mode;
            peak   <= '0;
            wptr   <= '0;
            state  <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (data_in_valid) begin
            wptr <= wptr + AW'(1);
            for (int c = 0; c < CH; c++) begin
              if (abs_mag(data_in[(CH-1-c)*DW +: DW]) > peak[c])
                peak[c] <= abs_mag(data_in[(CH-1-c)*DW +: DW]);
            end
            if (wptr == AW'(FRAME - 1)) state <= S_CALC;
          end
        end
        S_CALC: begin
          for (int c = 0; c < CH; c++) begin
            shift_out[(CH-1-c)*SW +: SW] <= mode_q ? '0 : calc_shift(peak[c]);
          end
          rptr  <= '0;
          state <= S_PREFETCH;
        end
        S_PREFETCH: begin
          // Load the first sample straight into the output register.
          data_out       <= apply_shift(mem[rptr], shift_out);
          data_out_valid <= 1'b1;
          state          <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (data_out_ready) begin
            if (rptr == AW'(FRAME - 1)) begin
              data_out_valid   <= 1'b0;
              process_end_flag <= 1'b1;
              state            <= S_IDLE;
            end else begin
              data_out <= apply_shift(mem[rptr_nxt], shift_out);
              rptr     <= rptr_nxt;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multich_frame_normalizer.sv
// Self-checking bench for multich_frame_normalizer (CH=2, DW=16, FRAME=4).
module tb_multich_frame_normalizer;

  localparam int CH    = 2;
  localparam int DW    = 16;
  localparam int FRAME = 4;
  localparam int SW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_flag = 1'b0;
  logic             mode = 1'b0;
  logic [CH*DW-1:0] data_in = '0;
  logic             data_in_valid = 1'b0;
  logic             data_in_ready;
  logic [CH*DW-1:0] data_out;
  logic             data_out_valid;
  logic             data_out_ready = 1'b1;
  logic [CH*SW-1:0] shift_out;
  logic             process_end_flag;

  multich_frame_normalizer #(.CH(CH), .DW(DW), .FRAME(FRAME), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start_flag(start_flag), .mode(mode),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .shift_out(shift_out), .process_end_flag(process_end_flag)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int hs_cnt = 0;
  int pe_cnt = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  logic pe_prev = 1'b0;
  logic [15:0] smp0 [FRAME];
  logic [15:0] smp1 [FRAME];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: magnitude and largest safe shift found by direct search.
  function automatic int mag(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [3:0] model_shift(input int pk, input logic m);
    int s;
    s = 0;
    if (m || pk == 0) return 4'd0;
    for (int k = 0; k <= 14; k++) begin
      if ((pk << k) <= 32767) s = k;
    end
    return 4'(s);
  endfunction

  // Scoreboard monitor: pops and compares on every handshake, checks end pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) check("extra_out", 32'(data_out_valid), 32'd0);
        else check("data_out", data_out, exp_q.pop_front());
        if (hs_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        hs_cnt++;
      end
      if (process_end_flag) begin
        check("pe_q_empty", 32'(exp_q.size()), 32'd0);
        check("pe_timing", 32'(cyc), 32'(last_pop_cyc + 1));
        check("pe_width", 32'(pe_prev), 32'd0);
        pe_cnt++;
      end
    end
    pe_prev = process_end_flag;
  end

  task automatic check_idle(input string tag);
    check({tag, "_dout"},  data_out, 32'd0);
    check({tag, "_valid"}, 32'(data_out_valid), 32'd0);
    check({tag, "_shift"}, 32'(shift_out), 32'd0);
    check({tag, "_pe"},    32'(process_end_flag), 32'd0);
    check({tag, "_ready"}, 32'(data_in_ready), 32'd0);
  endtask

  task automatic set_frame(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    smp0[0] = a0; smp0[1] = a1; smp0[2] = a2; smp0[3] = a3;
    smp1[0] = b0; smp1[1] = b1; smp1[2] = b2; smp1[3] = b3;
  endtask

  // Driver: one frame with optional input gaps, backpressure, busy starts or abort.
  task automatic run_frame(input logic m, input bit gaps, input bit bp, input bit busy,
                           input bit abort);
    int pk0, pk1, sh_cyc, base;
    logic [3:0] e0, e1;
    logic [31:0] exp1;
    pk0 = 0; pk1 = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (mag(smp0[i]) > pk0) pk0 = mag(smp0[i]);
      if (mag(smp1[i]) > pk1) pk1 = mag(smp1[i]);
    end
    e0 = model_shift(pk0, m);
    e1 = model_shift(pk1, m);
    for (int i = 0; i < FRAME; i++) exp_q.push_back({smp0[i] << e0, smp1[i] << e1});
    exp1 = {smp0[1] << e0, smp1[1] << e1};
    hs_cnt = 0;
    data_out_ready = 1'b1;
    // Start, with a junk sample offered while still idle.
    @(posedge clk); #1;
    data_in = $urandom; data_in_valid = 1'b1; start_flag = 1'b1; mode = m;
    @(posedge clk); #1;
    start_flag = 1'b0; mode = ~m; data_in_valid = 1'b0;
    @(negedge clk);
    check("in_ready", 32'(data_in_ready), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          data_in = $urandom; data_in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      if (busy && i == 2) start_flag = 1'b1;
      data_in = {smp0[i], smp1[i]}; data_in_valid = 1'b1;
      @(posedge clk); #1;
      start_flag = 1'b0; data_in_valid = 1'b0; data_in = $urandom;
    end
    @(negedge clk);
    check("calc_ready", 32'(data_in_ready), 32'd0);
    check("calc_valid", 32'(data_out_valid), 32'd0);
    @(negedge clk);
    check("shift_out", 32'(shift_out), 32'({e0, e1}));
    check("pref_valid", 32'(data_out_valid), 32'd0);
    sh_cyc = cyc;
    if (abort) begin
      for (int k = 0; k < 20 && hs_cnt < 2; k++) @(negedge clk);
      check("abort_reach", 32'(hs_cnt >= 2), 32'd1);
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_idle("abort");
      return;
    end
    if (bp) begin
      @(posedge clk); #1;
      @(posedge clk); #1; data_out_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("bp_hold_data", data_out, exp1);
        check("bp_hold_valid", 32'(data_out_valid), 32'd1);
      end
      @(posedge clk); #1; data_out_ready = 1'b1;
    end else if (busy) begin
      @(posedge clk); #1; start_flag = 1'b1;
      @(posedge clk); #1; start_flag = 1'b0;
    end
    base = pe_cnt;
    for (int k = 0; k < 40 && pe_cnt == base; k++) @(negedge clk);
    check("pe_seen", 32'(pe_cnt - base), 32'd1);
    check("frame_hs", 32'(hs_cnt), 32'(FRAME));
    if (!bp) begin
      check("first_lat", 32'(first_pop_cyc - sh_cyc), 32'd1);
      check("burst_len", 32'(last_pop_cyc - first_pop_cyc), 32'(FRAME - 1));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs; start_flag forced high in the last reset cycle.
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      data_in = $urandom; data_in_valid = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      start_flag = (r == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle("reset");
    end
    rst_n = 1'b1; start_flag = 1'b0; data_in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(data_in_ready), 32'd0);

    // Normalize
    set_frame(16'd1, 16'hFFFE, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Full-scale and negative extreme
    set_frame(16'd100, 16'h8000, 16'd5, 16'd7, 16'd16383, 16'hFFFF, 16'd2, 16'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Backpressure on the second sample
    set_frame(16'd1, 16'hFFFE, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Bypass with input gaps
    set_frame(16'd1, 16'hFFFE, 16'd3, 16'd0, 16'd5, 16'hFF00, 16'd77, 16'd1);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Start pulses while busy, then reset mid-output, then a fresh frame
    set_frame(16'd1, 16'hFFFE, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_frame(16'd100, 16'h8000, 16'd5, 16'd7, 16'd16383, 16'hFFFF, 16'd2, 16'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Random frames of varying magnitude
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        smp0[i] = 16'($urandom_range(0, 16'h7FFF) >> $urandom_range(0, 14));
        smp1[i] = 16'($urandom_range(0, 16'h7FFF) >> $urandom_range(0, 14));
        if ($urandom_range(0, 1) == 1) smp0[i] = -smp0[i];
        if ($urandom_range(0, 1) == 1) smp1[i] = -smp1[i];
      end
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
